// File: rtl/control_multiciclo_pkg.sv
// rtl/control_multiciclo_pkg.sv - shared encodings for the multicycle control unit
package control_pkg;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_BRANCH, ST_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_IALU, CLS_BRANCH, CLS_LUI, CLS_ILLEGAL
   } op_class_t;

   // Same encoding is consumed by the immediate generator.
   typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_sel_t;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
   typedef enum logic [1:0] {TRAP_NONE = 2'b00, TRAP_ILLEGAL = 2'b01, TRAP_TIMEOUT = 2'b10} trap_code_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   function automatic imm_sel_t imm_sel_of(input op_class_t c);
      case (c)
         CLS_STORE:  return IMM_S;
         CLS_BRANCH: return IMM_B;
         CLS_LUI:    return IMM_U;
         default:    return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// rtl/control_multiciclo_if.sv - datapath/memory control bundle between controller and datapath
interface control_multiciclo_if;
   import control_pkg::*;

   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        ir_write;
   logic        pc_write;
   imm_sel_t    imm_sel;
   logic        alu_src;
   alu_op_t     alu_op;
   logic        reg_write;
   logic        mem_to_reg;
   logic        illegal_op;
   trap_code_t  trap_code;

   modport master (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, ir_write, pc_write, imm_sel, alu_src, alu_op,
             reg_write, mem_to_reg, illegal_op, trap_code
   );

   modport slave (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, ir_write, pc_write, imm_sel, alu_src, alu_op,
             reg_write, mem_to_reg, illegal_op, trap_code
   );

endinterface

// File: rtl/control_multiciclo_opcode_decoder.sv
// rtl/control_multiciclo_opcode_decoder.sv - opcode classification and immediate format
module opcode_decoder
   import control_pkg::*;
(
   input  logic [6:0] i_opcode,
   output op_class_t  o_class,
   output imm_sel_t   o_imm_sel
);

   always_comb begin
      case (i_opcode)
         OPC_LOAD:   o_class = CLS_LOAD;
         OPC_STORE:  o_class = CLS_STORE;
         OPC_RTYPE:  o_class = CLS_RTYPE;
         OPC_IALU:   o_class = CLS_IALU;
         OPC_BRANCH: o_class = CLS_BRANCH;
         OPC_LUI:    o_class = CLS_LUI;
         default:    o_class = CLS_ILLEGAL;
      endcase
   end

   assign o_imm_sel = imm_sel_of(o_class);

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle RISC-V style control FSM with memory timeout trap
module control_multiciclo
   import control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic                 clk,
   input  logic                 reset,
   control_multiciclo_if.slave  bus
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);

   state_t     r_state;
   logic [WW-1:0] r_wait;
   logic       r_illegal_op;
   trap_code_t r_trap_code;

   op_class_t  w_class;
   imm_sel_t   w_imm_sel;
   logic       w_timeout;
   logic       w_unused;

   opcode_decoder u_opcode_decoder (
      .i_opcode  (bus.instr[6:0]),
      .o_class   (w_class),
      .o_imm_sel (w_imm_sel)
   );

   // A ready strobe on the last allowed cycle wins over the timeout.
   assign w_timeout = !bus.mem_ready && (r_wait == WW'(MEM_TIMEOUT - 1));
   assign w_unused  = ^bus.instr[31:12];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_FETCH;
         r_wait       <= '0;
         r_illegal_op <= 1'b0;
         r_trap_code  <= TRAP_NONE;
      end else begin
         r_wait <= '0;
         case (r_state)
            ST_FETCH, ST_MEM: begin
               if (bus.mem_ready) begin
                  if (r_state == ST_FETCH)      r_state <= ST_DECODE;
                  else if (w_class == CLS_LOAD) r_state <= ST_WB;
                  else                          r_state <= ST_FETCH;
               end else if (w_timeout) begin
                  r_state      <= ST_TRAP;
                  r_illegal_op <= 1'b1;
                  r_trap_code  <= TRAP_TIMEOUT;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            ST_DECODE: begin
               if (w_class == CLS_ILLEGAL) begin
                  r_state      <= ST_TRAP;
                  r_illegal_op <= 1'b1;
                  r_trap_code  <= TRAP_ILLEGAL;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (w_class)
                  CLS_LOAD, CLS_STORE: r_state <= ST_MEM;
                  CLS_BRANCH:          r_state <= ST_BRANCH;
                  default:             r_state <= ST_WB;
               endcase
            end
            ST_WB, ST_BRANCH: r_state <= ST_FETCH;
            default:          r_state <= ST_TRAP;
         endcase
      end
   end

   always_comb begin
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.imm_sel    = IMM_I;
      bus.alu_src    = 1'b0;
      bus.alu_op     = ALU_ADD;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.illegal_op = 1'b0;
      bus.trap_code  = TRAP_NONE;
      if (!reset) begin
         case (r_state)
            ST_FETCH: begin
               bus.mem_req  = 1'b1;
               bus.ir_write = bus.mem_ready;
               bus.pc_write = bus.mem_ready;
            end
            ST_DECODE: bus.imm_sel = w_imm_sel;
            ST_EXEC: begin
               bus.imm_sel = w_imm_sel;
               case (w_class)
                  CLS_RTYPE: bus.alu_op = ALU_FUNCT;
                  CLS_IALU: begin
                     bus.alu_src = 1'b1;
                     bus.alu_op  = ALU_FUNCT;
                  end
                  CLS_LOAD, CLS_STORE, CLS_LUI: bus.alu_src = 1'b1;
                  CLS_BRANCH: bus.alu_op = ALU_SUB;
                  default: ;
               endcase
            end
            ST_MEM: begin
               bus.mem_req = 1'b1;
               bus.mem_we  = (w_class == CLS_STORE);
            end
            ST_WB: begin
               bus.reg_write  = |bus.instr[11:7];
               bus.mem_to_reg = (w_class == CLS_LOAD);
            end
            ST_BRANCH: begin
               bus.pc_write = bus.zero;
               bus.imm_sel  = IMM_B;
            end
            ST_TRAP: begin
               bus.illegal_op = r_illegal_op;
               bus.trap_code  = r_trap_code;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - directed and randomized checks of control_multiciclo against a step-plan model
module tb_control_multiciclo;

   localparam int TMO = 15;
   localparam int K_FETCH = 0, K_DECODE = 1, K_EXEC = 2, K_MEM = 3, K_WB = 4,
                  K_BRANCH = 5, K_TRAP_ILL = 6, K_TRAP_TMO = 7;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic [2:0] imm_sel;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
      logic       illegal_op;
      logic [1:0] trap_code;
   } outs_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   control_multiciclo_if bus();

   control_multiciclo #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int          plan[$];
   int          wait_cnt;
   bit          new_fetch;
   logic        cur_rst, cur_mr, cur_z;
   logic [31:0] cur_ins;
   outs_t       exp_o, smp;
   bit          exp_valid = 0;

   // 0 load, 1 store, 2 R-type, 3 I-ALU, 4 branch, 5 lui, 6 illegal
   function automatic int kind_of(input logic [31:0] ins);
      case (ins[6:0])
         7'b0000011: return 0;
         7'b0100011: return 1;
         7'b0110011: return 2;
         7'b0010011: return 3;
         7'b1100011: return 4;
         7'b0110111: return 5;
         default:    return 6;
      endcase
   endfunction

   function automatic void push_plan(input logic [31:0] ins);
      int kd;
      kd = kind_of(ins);
      plan.push_back(K_DECODE);
      if (kd == 6) begin
         plan.push_back(K_TRAP_ILL);
      end else begin
         plan.push_back(K_EXEC);
         if (kd == 0 || kd == 1) plan.push_back(K_MEM);
         if (kd == 4) plan.push_back(K_BRANCH);
         else if (kd != 1) plan.push_back(K_WB);
      end
   endfunction

   function automatic outs_t expect_out(input int k, input logic [31:0] ins,
                                        input logic rst, input logic mr, input logic z);
      outs_t      o;
      int         kd;
      logic [2:0] fmt;
      o   = '0;
      kd  = kind_of(ins);
      fmt = (kd == 1) ? 3'd1 : (kd == 4) ? 3'd2 : (kd == 5) ? 3'd3 : 3'd0;
      if (rst) return o;
      case (k)
         K_FETCH:  begin o.mem_req = 1'b1; o.ir_write = mr; o.pc_write = mr; end
         K_DECODE: o.imm_sel = fmt;
         K_EXEC: begin
            o.imm_sel = fmt;
            o.alu_src = (kd != 2 && kd != 4);
            o.alu_op  = (kd == 2 || kd == 3) ? 2'b10 : (kd == 4) ? 2'b01 : 2'b00;
         end
         K_MEM:      begin o.mem_req = 1'b1; o.mem_we = (kd == 1); end
         K_WB:       begin o.reg_write = (ins[11:7] != 5'd0); o.mem_to_reg = (kd == 0); end
         K_BRANCH:   begin o.pc_write = z; o.imm_sel = 3'd2; end
         K_TRAP_ILL: begin o.illegal_op = 1'b1; o.trap_code = 2'b01; end
         K_TRAP_TMO: begin o.illegal_op = 1'b1; o.trap_code = 2'b10; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic void model_advance();
      int k;
      if (cur_rst) begin
         plan.delete();
         plan.push_back(K_FETCH);
         wait_cnt  = 0;
         new_fetch = 1;
         return;
      end
      new_fetch = 0;
      k = plan[0];
      if (k == K_TRAP_ILL || k == K_TRAP_TMO) return;
      if (k == K_FETCH || k == K_MEM) begin
         if (!cur_mr) begin
            wait_cnt++;
            if (wait_cnt == TMO) begin
               plan.delete();
               plan.push_back(K_TRAP_TMO);
            end
            return;
         end
         wait_cnt = 0;
      end
      void'(plan.pop_front());
      if (k == K_FETCH) push_plan(cur_ins);
      if (plan.size() == 0) begin
         plan.push_back(K_FETCH);
         new_fetch = 1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic drive(input logic rst, input logic [31:0] ins, input logic mr, input logic z);
      cur_rst = rst; cur_ins = ins; cur_mr = mr; cur_z = z;
      reset = rst; bus.instr = ins; bus.mem_ready = mr; bus.zero = z;
      exp_o     = expect_out(plan[0], ins, rst, mr, z);
      exp_valid = 1;
      @(negedge clk);
      #1;
   endtask

   task automatic step(input logic rst, input logic [31:0] ins, input logic mr, input logic z);
      tick();
      drive(rst, ins, mr, z);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_valid) begin
         smp = {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.imm_sel, bus.alu_src,
                bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.illegal_op, bus.trap_code};
         checks++;
         if (smp !== exp_o) begin
            failures++;
            $display("FAIL outputs t=%0t got=%h want=%h", $time, smp, exp_o);
         end
         checks++;
         if (int'(smp.ir_write) + int'(smp.reg_write) + int'(smp.mem_req & smp.mem_we) > 1) begin
            failures++;
            $display("FAIL exclusive t=%0t got=%h want=at_most_one", $time, smp);
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: r[6:0] = 7'b0000011;
         1: r[6:0] = 7'b0100011;
         2: r[6:0] = 7'b0110011;
         3: r[6:0] = 7'b0010011;
         4: r[6:0] = 7'b1100011;
         5: r[6:0] = 7'b0110111;
         default: ;
      endcase
      if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
      return r;
   endfunction

   logic [31:0] lw, sw, beq, ill, ins;
   int          p, prev_k, k, trap_cycles;
   logic        rst, mr;

   initial begin
      lw = 32'h00A02083; sw = 32'h00302123; beq = 32'h00000463; ill = 32'h02000030;
      plan.push_back(K_FETCH);
      new_fetch = 1; wait_cnt = 0;
      reset = 1'b1; bus.instr = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
      cur_rst = 1'b1; cur_ins = '0; cur_mr = 1'b0; cur_z = 1'b0;

      step(1, lw, 1, 0);
      step(1, lw, 1, 0);
      chk("reset_outputs", 32'(smp), 0);

      step(0, lw, 1, 0);  chk("lw_c1_ir_write", smp.ir_write, 1); chk("lw_c1_pc_write", smp.pc_write, 1);
      step(0, lw, 1, 0);  chk("lw_c2_decode_no_req", smp.mem_req, 0);
      step(0, lw, 1, 0);  chk("lw_c3_imm_sel", smp.imm_sel, 0); chk("lw_c3_alu_src", smp.alu_src, 1);
      step(0, lw, 1, 0);  chk("lw_c4_mem_req", smp.mem_req, 1); chk("lw_c4_mem_we", smp.mem_we, 0);
      step(0, lw, 1, 0);  chk("lw_c5_reg_write", smp.reg_write, 1); chk("lw_c5_mem_to_reg", smp.mem_to_reg, 1);
      step(0, sw, 1, 0);  chk("lw_c6_fetch", {smp.mem_req, smp.mem_we}, 2'b10);
      step(0, sw, 1, 0);  chk("sw_decode_imm_sel", smp.imm_sel, 1);
      step(0, sw, 1, 0);  chk("sw_exec_imm_sel", smp.imm_sel, 1);
      step(0, sw, 1, 0);  chk("sw_mem_we", {smp.mem_req, smp.mem_we}, 2'b11); chk("sw_no_reg_write", smp.reg_write, 0);
      step(0, beq, 1, 1); chk("sw_c5_fetch", {smp.mem_req, smp.mem_we}, 2'b10);
      step(0, beq, 1, 1); chk("beq_decode_imm_sel", smp.imm_sel, 2);
      step(0, beq, 1, 1); chk("beq_exec_alu_op", smp.alu_op, 1); chk("beq_exec_imm_sel", smp.imm_sel, 2);
      step(0, beq, 1, 1); chk("beq_taken_pc_write", smp.pc_write, 1); chk("beq_taken_imm_sel", smp.imm_sel, 2);
      step(0, beq, 1, 0);
      step(0, beq, 1, 0);
      step(0, beq, 1, 0);
      step(0, beq, 1, 0); chk("beq_not_taken_pc_write", smp.pc_write, 0); chk("beq_nt_imm_sel", smp.imm_sel, 2);

      step(0, ill, 1, 0);
      step(0, ill, 1, 0); chk("ill_decode_no_trap", smp.illegal_op, 0);
      for (int i = 0; i < 20; i++) begin
         step(0, ill, $urandom_range(0, 1), 0);
         chk("ill_trap_held", {smp.illegal_op, smp.trap_code}, 3'b101);
      end
      step(1, ill, 0, 0); chk("ill_reset_clears", 32'(smp), 0);

      for (int i = 1; i <= TMO; i++) begin
         step(0, lw, 0, 0);
         if (i == 1) chk("tmo_first_fetch", {smp.mem_req, smp.illegal_op}, 2'b10);
      end
      chk("tmo_last_wait_req", smp.mem_req, 1);
      step(0, lw, 0, 0);  chk("tmo_trap", {smp.illegal_op, smp.trap_code}, 3'b110);
      step(1, lw, 0, 0);
      for (int i = 1; i < TMO; i++) step(0, lw, 0, 0);
      step(0, lw, 1, 0);  chk("tmo_ready_wins", smp.ir_write, 1);
      step(0, lw, 0, 0);  chk("tmo_ready_decode", {smp.mem_req, smp.trap_code}, 3'b000);
      step(0, lw, 0, 0);
      step(1, lw, 0, 0);  chk("mem_reset_outputs", 32'(smp), 0);
      step(0, lw, 0, 0);  chk("after_reset_fetch", smp.mem_req, 1);

      prev_k = -1; p = 60; trap_cycles = 0; ins = lw;
      for (int n = 0; n < 3000; n++) begin
         tick();
         k = plan[0];
         if (new_fetch) ins = rand_instr();
         if (k != prev_k || new_fetch) begin
            case ($urandom_range(0, 15))
               0:             p = 0;
               1, 2, 3, 4, 5: p = 15;
               default:       p = 60;
            endcase
         end
         prev_k = k;
         trap_cycles = (k == K_TRAP_ILL || k == K_TRAP_TMO) ? trap_cycles + 1 : 0;
         rst = ($urandom_range(0, 399) == 0) || (trap_cycles > 3 && $urandom_range(0, 3) == 0);
         mr  = ($urandom_range(0, 99) < p);
         drive(rst, ins, mr, 1'($urandom_range(0, 1)));
      end

      exp_valid = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum number of cycles to wait for mem_ready in one memory access.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  32  instruction register contents, stable from DECODE until return to FETCH.
REQ-005 zero  input  1  ALU zero flag, valid in BRANCH.
REQ-006 mem_ready  input  1  memory completion strobe for the current request.
REQ-007 mem_req  output  1  memory request, held until mem_ready or timeout.
REQ-008 mem_we  output  1  write qualifier for mem_req (store).
REQ-009 ir_write, pc_write  output  1 each  instruction register load; PC update.
REQ-010 imm_sel  output  3  immediate format for the immediate generator: 0=I, 1=S, 2=B, 3=U, 4=J.
REQ-011 alu_src  output  1  ALU operand B: 0=register, 1=immediate.
REQ-012 alu_op  output  2  00=add, 01=sub, 10=decode funct3/funct7.
REQ-013 reg_write, mem_to_reg  output  1 each  register file write enable; write-back source select (1=memory).
REQ-014 illegal_op  output  1  sticky trap flag.
REQ-015 trap_code  output  2  00=none, 01=illegal opcode, 10=memory timeout.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, BRANCH and TRAP; outputs are decoded from the registered state and instr.
REQ-017 FETCH SHALL assert mem_req=1 and mem_we=0; in the cycle mem_ready=1 it SHALL assert ir_write and pc_write and go to DECODE.
REQ-018 DECODE SHALL last one cycle, drive imm_sel from opcode, and go to EXEC for opcodes 0000011, 0100011, 0110011, 0010011, 1100011 and 0110111; any other opcode SHALL go to TRAP with trap_code=01.
REQ-019 EXEC, R-type: alu_src=0, alu_op=10, next WB.
REQ-020 EXEC, I-ALU: alu_src=1, alu_op=10, imm_sel=I, next WB.
REQ-021 EXEC, LW/SW: alu_src=1, alu_op=00, imm_sel=I or S respectively, next MEM.
REQ-022 EXEC, LUI: imm_sel=U, alu_src=1, next WB.
REQ-023 EXEC, BEQ: alu_src=0, alu_op=01, imm_sel=B, next BRANCH.
REQ-024 BRANCH SHALL assert pc_write=zero and alu_op=00, imm_sel=B, then go to FETCH.
REQ-025 MEM SHALL assert mem_req=1 with mem_we=1 for SW and mem_we=0 for LW.
REQ-026 On mem_ready, MEM SHALL go to FETCH for SW and to WB for LW.
REQ-027 WB SHALL assert reg_write for one cycle, with mem_to_reg=1 only for LW; reg_write SHALL be suppressed when instr[11:7]=0.
REQ-028 A wait counter SHALL clear on entry to FETCH or MEM and count cycles with mem_ready=0.
REQ-029 On the cycle the wait counter reaches MEM_TIMEOUT, the block SHALL go to TRAP with trap_code=10.
REQ-030 If mem_ready=1 in the same cycle the wait counter reaches MEM_TIMEOUT, mem_ready SHALL win.
REQ-031 TRAP SHALL hold illegal_op=1 and trap_code, with all other outputs 0, until reset.
REQ-032 At most one of ir_write, reg_write and mem_req-with-mem_we SHALL be active in any cycle.

Reset
REQ-033 While reset=1 at a clock edge, the state SHALL become FETCH, the wait counter 0, illegal_op=0 and trap_code=00.
REQ-034 While reset is high, all outputs SHALL be forced to 0, including mid-access, where mem_req drops in the reset cycle.
REQ-035 The first cycle after reset deasserts SHALL be FETCH with mem_req=1.

Structure
REQ-036 A shared package control_pkg SHALL hold the state enum, the opcode constants, and the imm_sel, alu_op and trap_code encodings; the immediate generator SHALL use the same imm_sel encoding.
REQ-037 Opcode classification SHALL live in one combinational sub-module, opcode_decoder, instantiated once.

Verification
REQ-038 LW, instr=0x00A02083, mem_ready=1 on every request -> FETCH,DECODE,EXEC,MEM,WB in 5 cycles; imm_sel=0 in EXEC; reg_write=1 and mem_to_reg=1 in cycle 5; FETCH in cycle 6.
REQ-039 SW, instr=0x00302123 -> imm_sel=1; mem_we=1 in MEM; reg_write never asserted; FETCH after 4 cycles.
REQ-040 BEQ, instr=0x00000463, with zero=1 then zero=0 -> pc_write=1 in BRANCH for the first run only; imm_sel=2 in both runs.
REQ-041 Illegal opcode, instr=0x02000030 -> TRAP after DECODE; illegal_op=1, trap_code=01, held 20 cycles until reset.
REQ-042 Memory timeout and reset, MEM_TIMEOUT=15 -> mem_ready=0 in FETCH for 15 cycles gives TRAP with trap_code=10; mem_ready on the 15th cycle gives DECODE; reset asserted in MEM gives all outputs 0 that cycle and FETCH afterwards.
